// File: rtl/cmp_ext_pkg.sv
// Shared encodings for the comparator/extender pipeline: compare opcodes, extension modes
// and the width of the true-lane counter.
package cmp_ext_pkg;

  localparam logic [2:0] OP_LT = 3'd0;
  localparam logic [2:0] OP_LE = 3'd1;
  localparam logic [2:0] OP_EQ = 3'd2;
  localparam logic [2:0] OP_NE = 3'd3;
  localparam logic [2:0] OP_GT = 3'd4;
  localparam logic [2:0] OP_GE = 3'd5;

  localparam logic EXT_ZERO = 1'b0;
  localparam logic EXT_ONES = 1'b1;

  // Bits needed to hold a count in 0..n inclusive.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/cmp_ext_lane.sv
// One comparator lane: compares a and b under the selected op and signedness, then
// zero- or ones-extends the 1-bit outcome to RES_WIDTH.
module cmp_ext_lane
  import cmp_ext_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned RES_WIDTH  = 3
) (
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic [2:0]            op_i,
  input  logic                  signed_i,
  input  logic                  ext_i,
  output logic                  bit_o,
  output logic [RES_WIDTH-1:0]  res_o
);

  logic lt;
  logic eq;

  always_comb begin
    if (signed_i) begin
      lt = $signed(a_i) < $signed(b_i);
    end else begin
      lt = a_i < b_i;
    end
    eq = (a_i == b_i);
  end

  always_comb begin
    case (op_i)
      OP_LT:   bit_o = lt;
      OP_LE:   bit_o = lt | eq;
      OP_EQ:   bit_o = eq;
      OP_NE:   bit_o = ~eq;
      OP_GT:   bit_o = ~(lt | eq);
      OP_GE:   bit_o = ~lt;
      default: bit_o = 1'b0;
    endcase
  end

  // With RES_WIDTH == 1 both branches collapse to the bare bit.
  assign res_o = (ext_i == EXT_ZERO) ? RES_WIDTH'(bit_o) : {RES_WIDTH{bit_o}};

endmodule

// File: rtl/cmp_ext_pipe.sv
// Two-stage valid/ready pipeline: S1 registers operands and controls, S2 registers the
// per-lane extended results and the count of true lanes.
module cmp_ext_pipe
  import cmp_ext_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned RES_WIDTH  = 3,
  parameter int unsigned CHANNELS   = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [CHANNELS*DATA_WIDTH-1:0]     dataIn_a,
  input  logic [CHANNELS*DATA_WIDTH-1:0]     dataIn_b,
  input  logic [2:0]                         dataIn_op,
  input  logic                               dataIn_signed,
  input  logic                               dataIn_ext,
  input  logic                               dataIn_vld,
  output logic                               dataIn_rd,
  output logic [CHANNELS*RES_WIDTH-1:0]      dataOut_res,
  output logic [cnt_width(CHANNELS)-1:0]     dataOut_cnt,
  output logic                               dataOut_vld,
  input  logic                               dataOut_rd
);

  localparam int unsigned CntW = cnt_width(CHANNELS);

  logic                           s1_vld_q;
  logic [CHANNELS*DATA_WIDTH-1:0] a_q;
  logic [CHANNELS*DATA_WIDTH-1:0] b_q;
  logic [2:0]                     op_q;
  logic                           signed_q;
  logic                           ext_q;

  logic                           s2_vld_q;
  logic [CHANNELS*RES_WIDTH-1:0]  res_q;
  logic [CntW-1:0]                cnt_q;

  logic [CHANNELS-1:0]            lane_bit;
  logic [CHANNELS*RES_WIDTH-1:0]  res_d;
  logic [CntW-1:0]                cnt_d;

  logic s1_en;
  logic in_xfer;

  assign s1_en     = !s2_vld_q || dataOut_rd;
  assign dataIn_rd = !rst && (!s1_vld_q || s1_en);
  assign in_xfer   = dataIn_vld && dataIn_rd;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    cmp_ext_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .RES_WIDTH (RES_WIDTH)
    ) u_lane (
      .a_i     (a_q[g*DATA_WIDTH +: DATA_WIDTH]),
      .b_i     (b_q[g*DATA_WIDTH +: DATA_WIDTH]),
      .op_i    (op_q),
      .signed_i(signed_q),
      .ext_i   (ext_q),
      .bit_o   (lane_bit[g]),
      .res_o   (res_d[g*RES_WIDTH +: RES_WIDTH])
    );
  end

  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d = cnt_d + CntW'(lane_bit[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      signed_q <= 1'b0;
      ext_q    <= 1'b0;
      s2_vld_q <= 1'b0;
      res_q    <= '0;
      cnt_q    <= '0;
    end else begin
      if (in_xfer) begin
        s1_vld_q <= 1'b1;
        a_q      <= dataIn_a;
        b_q      <= dataIn_b;
        op_q     <= dataIn_op;
        signed_q <= dataIn_signed;
        ext_q    <= dataIn_ext;
      end else if (s1_en) begin
        s1_vld_q <= 1'b0;
      end
      // S2 only captures real transactions so its data holds across bubbles.
      if (s1_en) begin
        s2_vld_q <= s1_vld_q;
        if (s1_vld_q) begin
          res_q <= res_d;
          cnt_q <= cnt_d;
        end
      end
    end
  end

  assign dataOut_vld = s2_vld_q;
  assign dataOut_res = res_q;
  assign dataOut_cnt = cnt_q;

endmodule

// File: tb/tb_cmp_ext_pipe.sv
// Scoreboard bench for cmp_ext_pipe: directed vectors with hand-computed results, plus a
// single-lane, 1-bit-result instance.
module tb_cmp_ext_pipe;

  localparam int DW = 8;
  localparam int RW = 3;
  localparam int CH = 4;
  localparam int CW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [CH*DW-1:0]  a, b;
  logic [2:0]        op;
  logic              sgn, ext, in_vld, in_rd;
  logic [CH*RW-1:0]  res;
  logic [CW-1:0]     cnt;
  logic              out_vld, out_rd;

  logic [7:0] a1, b1;
  logic [2:0] op1;
  logic       sgn1, ext1, vld1, in_rd1;
  logic [0:0] res1, cnt1;
  logic       ovld1, ord1;

  cmp_ext_pipe #(.DATA_WIDTH(DW), .RES_WIDTH(RW), .CHANNELS(CH)) dut (
    .clk(clk), .rst(rst), .dataIn_a(a), .dataIn_b(b), .dataIn_op(op),
    .dataIn_signed(sgn), .dataIn_ext(ext), .dataIn_vld(in_vld), .dataIn_rd(in_rd),
    .dataOut_res(res), .dataOut_cnt(cnt), .dataOut_vld(out_vld), .dataOut_rd(out_rd)
  );

  cmp_ext_pipe #(.DATA_WIDTH(8), .RES_WIDTH(1), .CHANNELS(1)) dut1 (
    .clk(clk), .rst(rst), .dataIn_a(a1), .dataIn_b(b1), .dataIn_op(op1),
    .dataIn_signed(sgn1), .dataIn_ext(ext1), .dataIn_vld(vld1), .dataIn_rd(in_rd1),
    .dataOut_res(res1), .dataOut_cnt(cnt1), .dataOut_vld(ovld1), .dataOut_rd(ord1)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [11:0] res;
    logic [2:0]  cnt;
    int          stamp;
    bit          lat;
  } exp_t;
  exp_t q[$];
  logic [1:0] q1[$];

  // Lane 0 is the least significant byte.
  localparam logic [31:0] VA = 32'hFF10_8001;
  localparam logic [31:0] VB = 32'h0010_7F02;
  localparam logic [31:0] VE = 32'h1234_5678;

  logic [31:0] v_a   [12] = '{VA, VA, VA, VA, VE, VE, VE, VA, VA, VA, VA, VA};
  logic [31:0] v_b   [12] = '{VB, VB, VB, VB, VE, VE, VE, VB, VB, VB, VB, VB};
  logic [2:0]  v_op  [12] = '{0, 5, 4, 0, 2, 3, 6, 7, 1, 1, 4, 5};
  logic        v_sgn [12] = '{0, 1, 0, 1, 0, 0, 0, 1, 0, 1, 1, 0};
  logic        v_ext [12] = '{0, 1, 0, 1, 0, 0, 0, 1, 1, 0, 1, 1};
  logic [11:0] v_res [12] = '{12'h001, 12'h1C0, 12'h208, 12'hE3F, 12'h249, 12'h000,
                              12'h000, 12'h000, 12'h1C7, 12'h249, 12'h000, 12'hFF8};
  logic [2:0]  v_cnt [12] = '{1, 1, 2, 3, 4, 0, 0, 0, 2, 4, 0, 3};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // 0: ready always, 1: repeating 1,0,0,1 pattern, 2: never ready
  int       rd_mode = 0;
  int       pidx = 0;
  bit [3:0] pat = 4'b1001;
  always @(negedge clk) begin
    case (rd_mode)
      0: out_rd = 1'b1;
      1: begin
        out_rd = pat[pidx];
        pidx   = (pidx + 1) % 4;
      end
      default: out_rd = 1'b0;
    endcase
  end

  task automatic send(input int i, input bit lat);
    int   budget;
    exp_t e;
    @(negedge clk);
    a = v_a[i]; b = v_b[i]; op = v_op[i]; sgn = v_sgn[i]; ext = v_ext[i];
    in_vld = 1'b1;
    #1;
    budget = 0;
    while (!in_rd && budget < 50) begin
      @(negedge clk);
      #1;
      budget++;
    end
    if (!in_rd) begin
      chk("send_timeout", 32'(in_rd), 32'd1);
    end else begin
      e.res = v_res[i]; e.cnt = v_cnt[i]; e.stamp = cyc; e.lat = lat;
      q.push_back(e);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_vld = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || q1.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0 || q1.size() != 0) chk("drain_timeout", 32'(q.size() + q1.size()), 0);
  endtask

  logic        snap_v = 1'b0;
  logic [11:0] snap_res;
  logic [2:0]  snap_cnt;

  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (rst) begin
      snap_v = 1'b0;
    end else begin
      if (!in_rd) chk("rd_low_only_when_stalled", {30'd0, out_vld, out_rd}, 32'd2);
      if (snap_v) begin
        chk("stall_vld", 32'(out_vld), 32'd1);
        chk("stall_res", 32'(res), 32'(snap_res));
        chk("stall_cnt", 32'(cnt), 32'(snap_cnt));
        snap_v = 1'b0;
      end
      if (out_vld) begin
        if (out_rd) begin
          if (q.size() == 0) begin
            chk("unexpected_output", 32'(res), 32'hFFFF_FFFF);
          end else begin
            e = q.pop_front();
            chk("res", 32'(res), 32'(e.res));
            chk("cnt", 32'(cnt), 32'(e.cnt));
            if (e.lat) chk("latency", 32'(cyc - e.stamp), 32'd2);
          end
        end else begin
          snap_v   = 1'b1;
          snap_res = res;
          snap_cnt = cnt;
        end
      end
    end
  end

  always begin
    logic [1:0] e1;
    @(negedge clk);
    #2;
    if (!rst && ovld1) begin
      if (q1.size() == 0) begin
        chk("w1_unexpected_output", {30'd0, res1, cnt1}, 32'hFFFF_FFFF);
      end else begin
        e1 = q1.pop_front();
        chk("w1_res", 32'(res1), 32'(e1[1]));
        chk("w1_cnt", 32'(cnt1), 32'(e1[0]));
      end
    end
  end

  task automatic send1(input logic [2:0] o, input logic [1:0] expv);
    int budget;
    @(negedge clk);
    a1 = 8'h5A; b1 = 8'h5A; op1 = o; sgn1 = 1'b0; ext1 = 1'b1; vld1 = 1'b1;
    #1;
    budget = 0;
    while (!in_rd1 && budget < 50) begin
      @(negedge clk);
      #1;
      budget++;
    end
    if (!in_rd1) chk("w1_send_timeout", 32'(in_rd1), 32'd1);
    else q1.push_back(expv);
  endtask

  initial begin
    rst = 1'b1; in_vld = 1'b0; a = '0; b = '0; op = '0; sgn = 1'b0; ext = 1'b0;
    vld1 = 1'b0; a1 = '0; b1 = '0; op1 = '0; sgn1 = 1'b0; ext1 = 1'b0; ord1 = 1'b1;
    out_rd = 1'b1;

    repeat (2) @(negedge clk);
    #1;
    chk("rd_during_rst", 32'(in_rd), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_vld", 32'(out_vld), 32'd0);
    chk("rst_res", 32'(res), 32'd0);
    chk("rst_cnt", 32'(cnt), 32'd0);
    chk("rst_rd", 32'(in_rd), 32'd1);

    // Unsigned LT then signed GE on the same operands, ready held high.
    send(0, 1'b1);
    send(1, 1'b1);
    idle();
    drain();

    // Eight-deep stream against a stalling consumer.
    rd_mode = 1;
    for (int i = 0; i < 8; i++) send(i, 1'b0);
    idle();
    drain();

    // Reserved opcode alone, then the remaining ops back to back.
    rd_mode = 0;
    send(6, 1'b1);
    idle();
    drain();
    for (int i = 8; i < 12; i++) send(i, 1'b1);
    idle();
    drain();

    // Fill both stages, reset, and confirm in-flight data is gone.
    rd_mode = 2;
    send(2, 1'b0);
    send(3, 1'b0);
    @(negedge clk);
    in_vld = 1'b0;
    rst = 1'b1;
    #1;
    chk("rd_during_rst2", 32'(in_rd), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    rd_mode = 0;
    #1;
    chk("rst2_vld", 32'(out_vld), 32'd0);
    chk("rst2_res", 32'(res), 32'd0);
    chk("rst2_cnt", 32'(cnt), 32'd0);
    chk("rst2_rd", 32'(in_rd), 32'd1);
    send(4, 1'b1);
    idle();
    drain();

    // Single-lane, 1-bit result: EQ true with ones-extend, then NE false.
    send1(3'd2, 2'b11);
    send1(3'd3, 2'b00);
    @(negedge clk);
    vld1 = 1'b0;
    drain();

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
